// File: rtl/adapter_ul_pack.sv
// Uplink adapter: packs DDC AXI-Stream IQ samples into CPRI words,
// buffers them in a small FIFO and releases one word per CPRI request.
module adapter_ul_pack #(
  parameter int SAMPLE_W = 16,
  parameter int PACK     = 2,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*SAMPLE_W-1:0]      axis_tdata,
  input  logic                       axis_tvalid,
  output logic                       axis_tready,
  input  logic                       iq_tx_req,
  output logic [PACK*SAMPLE_W-1:0]   iq_tx_i,
  output logic [PACK*SAMPLE_W-1:0]   iq_tx_q,
  output logic                       iq_tx_valid,
  input  logic                       sync_clr,
  output logic                       underflow,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int WW = PACK * SAMPLE_W;
  localparam int HW = ((PACK > 1) ? PACK - 1 : 1) * SAMPLE_W;
  localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] LAST = CW'(PACK - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [CW-1:0]       pack_cnt;
  logic [HW-1:0]       hold_i;
  logic [HW-1:0]       hold_q;
  logic [WW-1:0]       word_i;
  logic [WW-1:0]       word_q;
  logic [SAMPLE_W-1:0] s_i;
  logic [SAMPLE_W-1:0] s_q;
  logic [2*WW-1:0]     mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                clr;
  logic                at_last;
  logic                full;
  logic                empty;
  logic                accept;
  logic                push;
  logic                pop;

  assign s_i     = axis_tdata[SAMPLE_W-1:0];
  assign s_q     = axis_tdata[2*SAMPLE_W-1:SAMPLE_W];
  assign clr     = rst | sync_clr;
  assign at_last = (pack_cnt == LAST);
  assign full    = (fifo_level == FULL);
  assign empty   = (fifo_level == '0);

  // Only the word-completing sample can be refused, so nothing is lost.
  assign axis_tready = ~(full & at_last);
  assign accept      = axis_tvalid & axis_tready;
  assign push        = accept & at_last;
  assign pop         = iq_tx_req & ~empty;

  always_comb begin
    word_i = '0;
    word_q = '0;
    for (int k = 0; k < PACK - 1; k++) begin
      word_i[k*SAMPLE_W +: SAMPLE_W] = hold_i[k*SAMPLE_W +: SAMPLE_W];
      word_q[k*SAMPLE_W +: SAMPLE_W] = hold_q[k*SAMPLE_W +: SAMPLE_W];
    end
    word_i[(PACK-1)*SAMPLE_W +: SAMPLE_W] = s_i;
    word_q[(PACK-1)*SAMPLE_W +: SAMPLE_W] = s_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pack_cnt <= '0;
      hold_i   <= '0;
      hold_q   <= '0;
    end else if (accept) begin
      for (int k = 0; k < PACK - 1; k++) begin
        if (pack_cnt == CW'(k)) begin
          hold_i[k*SAMPLE_W +: SAMPLE_W] <= s_i;
          hold_q[k*SAMPLE_W +: SAMPLE_W] <= s_q;
        end
      end
      pack_cnt <= at_last ? '0 : pack_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr] <= {word_q, word_i};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Emptiness is judged before this edge's push: no bypass path.
  always_ff @(posedge clk) begin
    if (clr) begin
      iq_tx_i     <= '0;
      iq_tx_q     <= '0;
      iq_tx_valid <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      iq_tx_valid <= pop;
      if (pop) begin
        {iq_tx_q, iq_tx_i} <= mem[rd_ptr];
      end
      if (iq_tx_req && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adapter_ul_pack.sv
// Scoreboard bench for adapter_ul_pack: default build plus a
// PACK=4 / SAMPLE_W=12 build sharing clock and reset.
module tb_adapter_ul_pack;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] a_tdata;
  logic        a_tvalid;
  logic        a_tready;
  logic        a_req;
  logic [31:0] a_i;
  logic [31:0] a_q;
  logic        a_valid;
  logic        a_clr;
  logic        a_uf;
  logic [3:0]  a_level;

  logic [23:0] b_tdata;
  logic        b_tvalid;
  logic        b_tready;
  logic        b_req;
  logic [47:0] b_i;
  logic [47:0] b_q;
  logic        b_valid;
  logic        b_clr;
  logic        b_uf;
  logic [3:0]  b_level;

  logic [63:0] qa[$];
  logic [95:0] qb[$];

  int n_chk  = 0;
  int n_fail = 0;

  adapter_ul_pack #(
    .SAMPLE_W(16),
    .PACK(2),
    .DEPTH(8)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .axis_tdata (a_tdata),
    .axis_tvalid(a_tvalid),
    .axis_tready(a_tready),
    .iq_tx_req  (a_req),
    .iq_tx_i    (a_i),
    .iq_tx_q    (a_q),
    .iq_tx_valid(a_valid),
    .sync_clr   (a_clr),
    .underflow  (a_uf),
    .fifo_level (a_level)
  );

  adapter_ul_pack #(
    .SAMPLE_W(12),
    .PACK(4),
    .DEPTH(8)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .axis_tdata (b_tdata),
    .axis_tvalid(b_tvalid),
    .axis_tready(b_tready),
    .iq_tx_req  (b_req),
    .iq_tx_i    (b_i),
    .iq_tx_q    (b_q),
    .iq_tx_valid(b_valid),
    .sync_clr   (b_clr),
    .underflow  (b_uf),
    .fifo_level (b_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [31:0] d);
    int n;
    n = 0;
    a_tdata  = d;
    a_tvalid = 1'b1;
    while (a_tready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL a_send_timeout: got tready=0 expected 1");
    end
    step();
    a_tvalid = 1'b0;
  endtask

  task automatic send_b(input logic [23:0] d);
    int n;
    n = 0;
    b_tdata  = d;
    b_tvalid = 1'b1;
    while (b_tready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL b_send_timeout: got tready=0 expected 1");
    end
    step();
    b_tvalid = 1'b0;
  endtask

  task automatic req_a();
    a_req = 1'b1;
    step();
    a_req = 1'b0;
  endtask

  task automatic clr_a();
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
  endtask

  always @(negedge clk) begin : mon_a
    logic [63:0] e;
    if (a_valid === 1'b1) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_word: got %0h expected none",
                 {a_q, a_i});
      end else begin
        e = qa.pop_front();
        chk("a_word", 96'({a_q, a_i}), 96'(e));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [95:0] e;
    if (b_valid === 1'b1) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_word: got %0h expected none",
                 {b_q, b_i});
      end else begin
        e = qb.pop_front();
        chk("b_word", {b_q, b_i}, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] si;
    logic [15:0] sq;
    rst      = 1'b1;
    a_tdata  = '0;
    a_tvalid = 1'b0;
    a_req    = 1'b0;
    a_clr    = 1'b0;
    b_tdata  = '0;
    b_tvalid = 1'b0;
    b_req    = 1'b0;
    b_clr    = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst_level", 96'(a_level), 96'(0));
    chk("rst_uf", 96'(a_uf), 96'(0));
    chk("rst_i", 96'(a_i), 96'(0));
    chk("rst_q", 96'(a_q), 96'(0));
    chk("rst_valid", 96'(a_valid), 96'(0));
    chk("rst_tready", 96'(a_tready), 96'(1));
    chk("rst_b_level", 96'(b_level), 96'(0));
    chk("rst_b_tready", 96'(b_tready), 96'(1));

    // basic pack and pop
    send_a(32'h0002_0001);
    chk("t1_level_half", 96'(a_level), 96'(0));
    send_a(32'h0004_0003);
    qa.push_back({32'h0004_0002, 32'h0003_0001});
    chk("t1_level_one", 96'(a_level), 96'(1));
    req_a();
    chk("t1_valid_lat", 96'(a_valid), 96'(1));
    chk("t1_level_zero", 96'(a_level), 96'(0));
    step();
    chk("t1_valid_pulse", 96'(a_valid), 96'(0));

    // underflow, sticky until sync_clr
    req_a();
    chk("uf_set", 96'(a_uf), 96'(1));
    chk("uf_valid", 96'(a_valid), 96'(0));
    chk("uf_i_hold", 96'(a_i), 96'(32'h0003_0001));
    chk("uf_q_hold", 96'(a_q), 96'(32'h0004_0002));
    step();
    chk("uf_sticky", 96'(a_uf), 96'(1));
    clr_a();
    chk("clr_uf", 96'(a_uf), 96'(0));
    chk("clr_level", 96'(a_level), 96'(0));
    chk("clr_i", 96'(a_i), 96'(0));

    // partial word discarded by sync_clr
    send_a(32'h0099_0098);
    clr_a();
    send_a(32'h000B_000A);
    send_a(32'h000D_000C);
    qa.push_back({32'h000D_000B, 32'h000C_000A});
    chk("part_level", 96'(a_level), 96'(1));
    req_a();
    step();
    chk("part_level_0", 96'(a_level), 96'(0));
    chk("part_no_uf", 96'(a_uf), 96'(0));

    // fill FIFO with no requests
    for (int n = 0; n < 16; n++) begin
      si = 16'h1000 + 16'(n);
      sq = 16'h2000 + 16'(n);
      chk("stream_tready", 96'(a_tready), 96'(1));
      send_a({sq, si});
      if (n % 2 == 1) begin
        qa.push_back({sq, sq - 16'd1, si, si - 16'd1});
      end
    end
    chk("full_level", 96'(a_level), 96'(8));
    chk("full_tready_k0", 96'(a_tready), 96'(1));
    send_a({16'h2010, 16'h1010});
    chk("full_tready_k1", 96'(a_tready), 96'(0));
    chk("full_level_k1", 96'(a_level), 96'(8));

    // request and completing sample on the same edge
    a_tdata  = {16'h2011, 16'h1011};
    a_tvalid = 1'b1;
    a_req    = 1'b1;
    step();
    a_req = 1'b0;
    chk("sim_level_7", 96'(a_level), 96'(7));
    chk("sim_tready", 96'(a_tready), 96'(1));
    step();
    a_tvalid = 1'b0;
    qa.push_back({16'h2011, 16'h2010, 16'h1011, 16'h1010});
    chk("sim_level_8", 96'(a_level), 96'(8));
    for (int n = 0; n < 8; n++) begin
      req_a();
    end
    step();
    chk("drain_level", 96'(a_level), 96'(0));
    chk("drain_uf", 96'(a_uf), 96'(0));

    // PACK=4, SAMPLE_W=12
    send_b({12'hA01, 12'h001});
    send_b({12'hA02, 12'h002});
    send_b({12'hA03, 12'h003});
    chk("b_level_part", 96'(b_level), 96'(0));
    send_b({12'hA04, 12'h004});
    qb.push_back({48'hA04A03A02A01, 48'h004003002001});
    chk("b_level_one", 96'(b_level), 96'(1));
    send_b({12'h800, 12'hFFF});
    send_b({12'h001, 12'h123});
    send_b({12'hABC, 12'h456});
    send_b({12'hDEF, 12'h789});
    qb.push_back({48'hDEFABC001800, 48'h789456123FFF});
    chk("b_level_two", 96'(b_level), 96'(2));
    b_req = 1'b1;
    step();
    chk("b_valid_lat", 96'(b_valid), 96'(1));
    step();
    b_req = 1'b0;
    step();
    chk("b_level_zero", 96'(b_level), 96'(0));
    chk("b_no_uf", 96'(b_uf), 96'(0));

    repeat (3) step();
    chk("qa_empty", 96'(qa.size()), 96'(0));
    chk("qb_empty", 96'(qb.size()), 96'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
